// File: rtl/reaction_ctrl_if.sv
// Signal bundle between the start-lights sequencer and its surroundings
// (LFSR, player button, lamp driver, score display).
interface reaction_ctrl_if #(
   parameter int N_WIDTH    = 5,
   parameter int K_WIDTH    = 7,
   parameter int OUT_WIDTH  = 8,
   parameter int TIME_WIDTH = 12
);
   logic [N_WIDTH-1:0]    n;
   logic                  start;
   logic                  react;
   logic [K_WIDTH-1:0]    rnd;
   logic [OUT_WIDTH-1:0]  data_out;
   logic                  busy;
   logic [TIME_WIDTH-1:0] result;
   logic                  result_valid;
   logic                  false_start;

   modport master (
      output n, start, react, rnd,
      input  data_out, busy, result, result_valid, false_start
   );

   modport slave (
      input  n, start, react, rnd,
      output data_out, busy, result, result_valid, false_start
   );
endinterface

// File: rtl/reaction_ctrl.sv
// F1 start-lights reaction game: lamp fill, random hold, reaction timing
// and jump-start detection, paced by an internal tick prescaler.
module reaction_ctrl #(
   parameter int N_WIDTH    = 5,
   parameter int K_WIDTH    = 7,
   parameter int OUT_WIDTH  = 8,
   parameter int STEP_TICKS = 4,
   parameter int TIME_WIDTH = 12
) (
   input logic           clk,
   input logic           rst,
   reaction_ctrl_if.slave bus
);
   localparam int                      STEP_W    = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
   localparam logic [STEP_W-1:0]       STEP_LAST = STEP_W'(STEP_TICKS - 1);
   localparam logic [2*OUT_WIDTH-1:0]  ALT_WIDE  = {OUT_WIDTH{2'b01}};
   localparam logic [OUT_WIDTH-1:0]    ALT       = ALT_WIDE[OUT_WIDTH-1:0];
   localparam logic [OUT_WIDTH-1:0]    ALL_ON    = '1;
   localparam logic [TIME_WIDTH-1:0]   TIME_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEQ,
      S_HOLD,
      S_GO,
      S_DONE,
      S_FAULT
   } state_t;

   state_t                r_state, w_state;
   logic [N_WIDTH-1:0]    r_cnt,    w_cnt;
   logic [STEP_W-1:0]     r_step,   w_step;
   logic [K_WIDTH-1:0]    r_hold,   w_hold;
   logic [TIME_WIDTH-1:0] r_timer,  w_timer;
   logic [OUT_WIDTH-1:0]  r_data,   w_data;
   logic                  r_busy,   w_busy;
   logic [TIME_WIDTH-1:0] r_result, w_result;
   logic                  r_valid,  w_valid;
   logic                  r_fs,     w_fs;
   logic                  w_tick;
   logic [OUT_WIDTH-1:0]  w_shifted;

   assign w_tick    = r_busy && (r_cnt == '0);
   assign w_shifted = {r_data[OUT_WIDTH-2:0], 1'b1};

   // NOTE: every signal written here gets its default first, so no path
   // through the case leaves one unassigned and infers a latch.
   always_comb begin
      w_state  = r_state;
      w_cnt    = r_cnt;
      w_step   = r_step;
      w_hold   = r_hold;
      w_timer  = r_timer;
      w_data   = r_data;
      w_result = r_result;
      w_valid  = r_valid;
      w_fs     = r_fs;

      if (r_busy) w_cnt = w_tick ? bus.n : r_cnt - 1'b1;

      case (r_state)
         S_IDLE, S_DONE, S_FAULT: begin
            if (bus.start) begin
               w_state = S_SEQ;
               w_data  = '0;
               w_valid = 1'b0;
               w_fs    = 1'b0;
               w_step  = '0;
               w_cnt   = bus.n;
            end
         end
         S_SEQ, S_HOLD: begin
            // A press before lights-out always wins over any tick this cycle.
            if (bus.react) begin
               w_state = S_FAULT;
               w_fs    = 1'b1;
               w_valid = 1'b0;
               w_data  = ALT;
            end else if (w_tick && r_state == S_SEQ) begin
               if (r_step == STEP_LAST) begin
                  w_step = '0;
                  w_data = w_shifted;
                  if (w_shifted == ALL_ON) begin
                     w_state = S_HOLD;
                     w_hold  = (bus.rnd == '0) ? K_WIDTH'(1) : bus.rnd;
                  end
               end else begin
                  w_step = r_step + 1'b1;
               end
            end else if (w_tick) begin
               if (r_hold == K_WIDTH'(1)) begin
                  w_state = S_GO;
                  w_data  = '0;
                  w_timer = '0;
               end else begin
                  w_hold = r_hold - 1'b1;
               end
            end
         end
         S_GO: begin
            if (bus.react) begin
               w_state  = S_DONE;
               w_result = r_timer;
               w_valid  = 1'b1;
            end else if (w_tick) begin
               if (r_timer == TIME_MAX) begin
                  w_state  = S_DONE;
                  w_result = TIME_MAX;
                  w_valid  = 1'b1;
               end else begin
                  w_timer = r_timer + 1'b1;
               end
            end
         end
         default: w_state = S_IDLE;
      endcase

      w_busy = (w_state == S_SEQ) || (w_state == S_HOLD) || (w_state == S_GO);
   end

   // NOTE: state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_step   <= '0;
         r_hold   <= '0;
         r_timer  <= '0;
         r_data   <= '0;
         r_busy   <= 1'b0;
         r_result <= '0;
         r_valid  <= 1'b0;
         r_fs     <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_step   <= w_step;
         r_hold   <= w_hold;
         r_timer  <= w_timer;
         r_data   <= w_data;
         r_busy   <= w_busy;
         r_result <= w_result;
         r_valid  <= w_valid;
         r_fs     <= w_fs;
      end
   end

   assign bus.data_out     = r_data;
   assign bus.busy         = r_busy;
   assign bus.result       = r_result;
   assign bus.result_valid = r_valid;
   assign bus.false_start  = r_fs;
endmodule

// File: tb/tb_reaction_ctrl.sv
// Scoreboard bench for reaction_ctrl: each round's outcome is predicted from
// tick arithmetic and checked by an independent monitor as the round runs.
module tb_reaction_ctrl;
   localparam int N_WIDTH    = 5;
   localparam int K_WIDTH    = 7;
   localparam int OUT_WIDTH  = 8;
   localparam int STEP_TICKS = 4;
   localparam int TIME_WIDTH = 12;
   localparam int F_TICKS    = STEP_TICKS * OUT_WIDTH;
   localparam int T_MAX      = (1 << TIME_WIDTH) - 1;
   localparam int ALT_VAL    = 8'h55;

   typedef struct {
      int period;
      int go_edge;
      int end_edge;
      int prev_result;
      int result;
      int valid;
      int fs;
      int data_end;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   int   model_result = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   reaction_ctrl_if #(
      .N_WIDTH(N_WIDTH), .K_WIDTH(K_WIDTH), .OUT_WIDTH(OUT_WIDTH), .TIME_WIDTH(TIME_WIDTH)
   ) bus ();

   reaction_ctrl #(
      .N_WIDTH(N_WIDTH), .K_WIDTH(K_WIDTH), .OUT_WIDTH(OUT_WIDTH),
      .STEP_TICKS(STEP_TICKS), .TIME_WIDTH(TIME_WIDTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: counts edges since busy rose and compares against the queue head.
   initial begin
      logic prev = 1'b0;
      int   cyc = 0;
      int   lamps;
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.busy === 1'b1 && prev !== 1'b1) begin
            cyc = 0;
            check("round_queued", q.size() > 0, 1);
            if (q.size() > 0) begin
               e = q[0];
               check("entry_result", bus.result, e.prev_result);
               check("entry_valid", bus.result_valid, 0);
               check("entry_false_start", bus.false_start, 0);
            end
         end else if (prev === 1'b1) begin
            cyc++;
         end
         if (bus.busy === 1'b1 && q.size() > 0) begin
            e = q[0];
            lamps = (cyc < e.go_edge) ? (cyc / e.period) / STEP_TICKS : 0;
            if (lamps > OUT_WIDTH) lamps = OUT_WIDTH;
            check("lamps", bus.data_out, (1 << lamps) - 1);
         end
         if (prev === 1'b1 && bus.busy !== 1'b1 && q.size() > 0) begin
            e = q.pop_front();
            check("end_edge", cyc, e.end_edge);
            check("end_result", bus.result, e.result);
            check("end_valid", bus.result_valid, e.valid);
            check("end_false_start", bus.false_start, e.fs);
            check("end_data_out", bus.data_out, e.data_end);
         end
         prev = bus.busy;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // One round: predict the outcome from tick arithmetic, queue it, then drive it.
   task automatic run_round(input int nv, input int rndv, input int react_edge,
                            input bit start_pulse, input int rst_edge, input bit react_with_start);
      exp_t e;
      int   p, g, tout, start_edge;
      p = nv + 1;
      g = (F_TICKS + ((rndv == 0) ? 1 : rndv)) * p;
      tout = g + (T_MAX + 1) * p;
      e.period = p;
      e.go_edge = g;
      e.prev_result = model_result;
      if (rst_edge >= 0) begin
         e.end_edge = rst_edge; e.result = 0; e.valid = 0; e.fs = 0; e.data_end = 0;
      end else if (react_edge >= 1 && react_edge <= g) begin
         e.end_edge = react_edge; e.result = model_result; e.valid = 0; e.fs = 1;
         e.data_end = ALT_VAL;
      end else if (react_edge > g && react_edge <= tout) begin
         e.end_edge = react_edge; e.result = (react_edge - 1 - g) / p;
         if (e.result > T_MAX) e.result = T_MAX;
         e.valid = 1; e.fs = 0; e.data_end = 0;
      end else begin
         e.end_edge = tout; e.result = T_MAX; e.valid = 1; e.fs = 0; e.data_end = 0;
      end
      model_result = e.result;
      q.push_back(e);
      start_edge = (start_pulse && e.end_edge > 1) ? $urandom_range(e.end_edge - 1, 1) : -1;

      @(negedge clk);
      bus.n = N_WIDTH'(nv);
      bus.start = 1'b1;
      bus.react = react_with_start;
      bus.rnd = K_WIDTH'($urandom);
      @(negedge clk);
      bus.start = 1'b0;
      bus.react = 1'b0;
      for (int k = 1; k <= e.end_edge + 2; k++) begin
         bus.react = (k == react_edge);
         bus.start = (k == start_edge);
         rst = (rst_edge >= 0) && (k == rst_edge || k == rst_edge + 1);
         bus.rnd = (k == F_TICKS * p) ? K_WIDTH'(rndv) : K_WIDTH'($urandom);
         @(negedge clk);
      end
      rst = 1'b0;
      bus.react = 1'b0;
      bus.start = 1'b0;
   endtask

   initial begin
      int nv, rndv, g, kind;
      rst = 1'b1;
      bus.n = '0;
      bus.start = 1'b0;
      bus.react = 1'b0;
      bus.rnd = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_data_out", bus.data_out, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_result", bus.result, 0);
      check("reset_valid", bus.result_valid, 0);
      check("reset_false_start", bus.false_start, 0);

      // n=0, rnd=3: lights out at edge 35, press sampled 11 edges later -> 10 ticks
      run_round(0, 3, 35 + 11, 1'b0, -1, 1'b0);
      // rnd=0 holds one tick; start pulses while busy must be ignored
      run_round(0, 0, 33 + 25, 1'b1, -1, 1'b0);
      // jump start while 0x07 is lit
      run_round(0, 5, 14, 1'b0, -1, 1'b0);
      // start and react together from FAULT: start wins, normal fill follows
      run_round(2, 3, 35 * 3 + 5, 1'b0, -1, 1'b1);
      // press exactly on the lights-out edge still counts as a jump start
      run_round(1, 2, 34 * 2, 1'b0, -1, 1'b0);
      // no press: timer saturates and times out, start during GO ignored
      run_round(0, 1, -1, 1'b1, -1, 1'b0);
      // reset for two cycles mid-GO, then a press must change nothing
      run_round(1, 5, 37 * 2 + 20, 1'b0, 37 * 2 + 10, 1'b0);
      model_result = 0;
      bus.react = 1'b1;
      @(negedge clk);
      bus.react = 1'b0;
      @(negedge clk);
      check("post_reset_busy", bus.busy, 0);
      check("post_reset_data_out", bus.data_out, 0);
      check("post_reset_result", bus.result, 0);
      check("post_reset_valid", bus.result_valid, 0);

      for (int i = 0; i < 16; i++) begin
         nv = $urandom_range(3, 0);
         rndv = $urandom_range(40, 0);
         g = (F_TICKS + ((rndv == 0) ? 1 : rndv)) * (nv + 1);
         kind = $urandom_range(9, 0);
         if (kind < 3)
            run_round(nv, rndv, $urandom_range(g, 1), $urandom_range(1, 0) == 1, -1,
                      $urandom_range(1, 0) == 1);
         else
            run_round(nv, rndv, $urandom_range(g + 60 * (nv + 1), g + 1),
                      $urandom_range(1, 0) == 1, -1, $urandom_range(1, 0) == 1);
      end

      repeat (5) @(negedge clk);
      check("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reaction_ctrl.md
Name: reaction_ctrl

Overview:
- Sequencer for the F1 start-lights reaction game.
- Fills the light bar one lamp per step, then holds all lamps lit for a random number of ticks taken from the external LFSR value.
- Then extinguishes all lamps and measures the player's reaction time in ticks.
- Detects jump starts. Sits between the LFSR and the light outputs and owns its own tick prescaler.

Parameters:
- N_WIDTH, 5, width of tick divider input n
- K_WIDTH, 7, width of random hold value rnd
- OUT_WIDTH, 8, number of lamps in data_out
- STEP_TICKS, 4, ticks per lamp during fill
- TIME_WIDTH, 12, width of reaction timer/result

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- n  input  N_WIDTH  prescaler: one tick every n+1 cycles
- start  input  1  begin a round (level sampled each cycle)
- react  input  1  player button
- rnd  input  K_WIDTH  random hold length in ticks, latched at fill completion
- data_out  output  OUT_WIDTH  lamp pattern
- busy  output  1  high in SEQ, HOLD, GO
- result  output  TIME_WIDTH  last reaction time in ticks
- result_valid  output  1  result holds a valid measurement
- false_start  output  1  last round aborted by early react

Behaviour:
- Reset (sync, clk edge with rst=1): state IDLE; data_out=0; busy=0; result=0; result_valid=0; false_start=0; all counters 0. rst overrides every other input, including mid-round.
- States: IDLE, SEQ, HOLD, GO, DONE, FAULT. busy is registered and equals (state in {SEQ,HOLD,GO}).
- Prescaler:
  - down-counter cnt, loaded with n on entry to SEQ.
  - tick = busy && cnt==0; on tick cnt reloads n, else it decrements.
  - n=0 gives a tick every cycle. n is sampled live; a change takes effect at the next reload.
- IDLE/DONE/FAULT:
  - start=1 -> SEQ next edge.
  - On that edge: data_out=0, result_valid=0, false_start=0, step counter=0, cnt=n. result retains its old value until overwritten.
  - react ignored.
  - start and react in the same cycle: start wins.
- SEQ:
  - step counter counts ticks 0..STEP_TICKS-1. On the tick that completes a step: data_out <= {data_out[OUT_WIDTH-2:0],1'b1}.
  - The step producing all-ones also moves to HOLD on the same edge and latches hold_cnt <= rnd, or 1 if rnd==0.
- HOLD:
  - each tick decrements hold_cnt.
  - tick with hold_cnt==1 -> GO on that edge; data_out <= 0, timer <= 0.
- GO:
  - each tick: timer <= timer+1, saturating at all-ones.
  - react=1 -> DONE. result <= current timer value, pre-increment if a tick coincides. result_valid <= 1.
  - Timer already all-ones on a tick with no react -> DONE with result = all-ones, result_valid=1 (timeout).
- react=1 in SEQ or HOLD -> FAULT next edge: false_start=1, result_valid=0, data_out=0x55 pattern (alternating, LSB lit, truncated/extended to OUT_WIDTH).
- start while busy: ignored.
- DONE: data_out=0. FAULT: data_out holds the alternating pattern. Both hold until start or rst.
- Outputs are registered; no combinational input-to-output paths.

Test Plan:
- Reset: assert rst 2 cycles mid-GO -> next edge all outputs 0, state IDLE; react afterwards has no effect.
- Fill timing, n=0, STEP_TICKS=4: pulse start -> busy=1 next edge; data_out=0x01 four cycles later; 0x03, 0x07, ..., 0xFF every 4 cycles; 0xFF 32 cycles after busy rises.
- Hold with rnd=3, n=0: data_out goes 0xFF -> 0x00 exactly 3 cycles later. Repeat with rnd=0 -> 0x00 after 1 cycle. With n=2, rnd=3 -> 9 cycles.
- Reaction: n=0, assert react 10 cycles after data_out goes 0 -> result=10, result_valid=1, busy=0. Assert start again -> result_valid clears, result still 10 until the next measurement.
- False start: react during SEQ at data_out=0x07 -> false_start=1, data_out=0x55, busy=0. Then start with react held low -> flags clear, normal fill resumes.
- Timeout/edge: TIME_WIDTH=4, never react -> result=15, result_valid=1. Start pressed during GO -> ignored, measurement unaffected.
